// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pkg.sv
// Shared definitions for the debounced AND3 cell: state encoding, counter width
// and the level decode used to derive Z from a state.
package gf180mcu_fd_sc_mcu7t5v0__pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_QUAL_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_QUAL_LO = 2'd3
    } dbnc_state_e;

    // Z keeps its old level while a change is still being qualified.
    function automatic logic level_of(input dbnc_state_e s);
        return (s == ST_HIGH) || (s == ST_QUAL_LO);
    endfunction

    function automatic logic is_qual(input dbnc_state_e s);
        return (s == ST_QUAL_HI) || (s == ST_QUAL_LO);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_1.sv
// Plain three-input AND gate feeding the debounce filter.
module gf180mcu_fd_sc_mcu7t5v0__and3_1 (
    input  logic A1,
    input  logic A2,
    input  logic A3,
    output logic Z
);

    assign Z = A1 & A2 & A3;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and3_dbnc_1.sv
// AND3 with optional input synchroniser and a FILT_CNT-sample debounce filter;
// Z, ZR, ZF and BUSY are all driven straight from flops.
module gf180mcu_fd_sc_mcu7t5v0__and3_dbnc_1
    import gf180mcu_fd_sc_mcu7t5v0__pkg::*;
#(
    parameter int FILT_CNT = 4,
    parameter int SYNC_EN  = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    output logic Z,
    output logic ZR,
    output logic ZF,
    output logic BUSY
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);
    localparam bit               BYPASS   = (FILT_CNT == 1);

    logic [2:0]       a_s;
    logic             c_s;
    dbnc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, zr_q, zf_q, busy_q;
    logic             z_d, zr_d, zf_d, busy_d;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [2:0] sync1_q, sync2_q;

            // Two-flop synchroniser for the asynchronous A inputs.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    sync1_q <= 3'b000;
                    sync2_q <= 3'b000;
                end else begin
                    sync1_q <= {A3, A2, A1};
                    sync2_q <= sync1_q;
                end
            end

            assign a_s = sync2_q;
        end else begin : g_nosync
            assign a_s = {A3, A2, A1};
        end
    endgenerate

    gf180mcu_fd_sc_mcu7t5v0__and3_1 u_and3 (
        .A1 (a_s[0]),
        .A2 (a_s[1]),
        .A3 (a_s[2]),
        .Z  (c_s)
    );

    // State, counter and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_LOW;
            cnt_q   <= CNT_ZERO;
            z_q     <= 1'b0;
            zr_q    <= 1'b0;
            zf_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            zr_q    <= zr_d;
            zf_q    <= zf_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; the >= compare keeps CNT from running past FILT_CNT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (c_s) begin
                    if (BYPASS) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_QUAL_HI;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_QUAL_HI: begin
                if (!c_s) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!c_s) begin
                    if (BYPASS) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_QUAL_LO;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_QUAL_LO: begin
                if (c_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode of the next state; edges compare against the current Z flop.
    always_comb begin
        z_d    = level_of(state_d);
        busy_d = is_qual(state_d);
        zr_d   = z_d & ~z_q;
        zf_d   = ~z_d & z_q;
    end

    assign Z    = z_q;
    assign ZR   = zr_q;
    assign ZF   = zf_q;
    assign BUSY = busy_q;

`ifdef GF180_TIMING_BUILD
    specify
        (CLK => Z)    = (1.0, 1.0);
        (CLK => ZR)   = (1.0, 1.0);
        (CLK => ZF)   = (1.0, 1.0);
        (CLK => BUSY) = (1.0, 1.0);
        $setup(RST, posedge CLK, 1.0);
        $hold(posedge CLK, RST, 1.0);
    endspecify
`endif

endmodule
